// File: rtl/corr_sequencer.sv
// corr_sequencer: start/busy/done sequencer for the correlation datapath.
// It reads ROM_A/ROM_B in lockstep and accumulates P = sum A[i]*B[i] for
// i = 0..N-1. The accumulator saturates instead of wrapping.
//
// Ports:
//   clk         rising-edge system clock
//   reset       asynchronous, active-low reset
//   start       run request; a rising edge seen in IDLE starts a run
//   sample_sel  N select: 0->1, 1->2, 2->4, 3->8 (latched at start)
//   rom_addr    registered address shared by both ROMs
//   rom_a_data  ROM_A read data, one cycle after rom_addr
//   rom_b_data  ROM_B read data, one cycle after rom_addr
//   busy        a run is in progress
//   done        sticky result-valid flag, cleared by the next accepted start
//   overflow    sticky flag: the last run's accumulation saturated
//   result      final correlation value, held until the next run completes
//   n_active    N latched for the current or last run
module corr_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        sample_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_a_data,
  input  logic [DATA_W-1:0] rom_b_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ACC_W-1:0]  result,
  output logic [3:0]        n_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ACC   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                start_q, start_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic [3:0]          n_active_q, n_active_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [3:0]          idx_q, idx_d;

  logic                start_rise;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    sat_sum;
  logic [3:0]          n_decoded;

  assign start_rise = start & ~start_q;
  assign prod       = (2*DATA_W)'(rom_a_data) * (2*DATA_W)'(rom_b_data);
  assign sum        = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod);
  // Once acc is all-ones any non-zero product carries out again, so the
  // saturated value is self-sustaining.
  assign sat_sum    = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

  always_comb begin
    n_decoded = 4'd1;
    case (sample_sel)
      2'd0:    n_decoded = 4'd1;
      2'd1:    n_decoded = 4'd2;
      2'd2:    n_decoded = 4'd4;
      default: n_decoded = 4'd8;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start;
    rom_addr_d = rom_addr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    result_d   = result_q;
    n_active_d = n_active_q;
    acc_d      = acc_q;
    idx_d      = idx_q;

    case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        rom_addr_d = '0;
        if (start_rise) begin
          n_active_d = n_decoded;
          acc_d      = '0;
          idx_d      = '0;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = PRIME;
        end
      end
      PRIME: begin
        // Address 0 is being read this cycle; its data arrives in the first ACC cycle.
        rom_addr_d = ADDR_W'(1);
        state_d    = ACC;
      end
      ACC: begin
        acc_d      = sat_sum;
        overflow_d = overflow_q | sum[ACC_W];
        idx_d      = idx_q + 4'd1;
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        if (idx_q == n_active_q - 4'd1) begin
          result_d   = sat_sum;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          rom_addr_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      result_q   <= '0;
      n_active_q <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      result_q   <= result_d;
      n_active_q <= n_active_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign result   = result_q;
  assign n_active = n_active_q;

endmodule

// File: tb/tb_corr_sequencer.sv
// tb_corr_sequencer: bench for corr_sequencer with registered ROM models.
// Expected run results are queued when a start is driven and popped when
// the run reports done.
module tb_corr_sequencer;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int ACC_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        sample_sel = 2'd0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_a_data;
  logic [DATA_W-1:0] rom_b_data;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ACC_W-1:0]  result;
  logic [3:0]        n_active;

  logic [DATA_W-1:0] rom_a [16];
  logic [DATA_W-1:0] rom_b [16];

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic [3:0] n;
  } exp_t;

  exp_t              sb [$];
  logic [ADDR_W-1:0] addr_trace [$];
  int                checks = 0;
  int                errors = 0;

  corr_sequencer #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sample_sel(sample_sel),
    .rom_addr  (rom_addr),
    .rom_a_data(rom_a_data),
    .rom_b_data(rom_b_data),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .result    (result),
    .n_active  (n_active)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs: one cycle of read latency.
  always @(posedge clk) begin
    rom_a_data <= rom_a[rom_addr];
    rom_b_data <= rom_b[rom_addr];
  end

  // Reference: exact integer sum, clamped to 255 when it exceeds 8 bits.
  function automatic exp_t model(input logic [1:0] sel);
    exp_t        e;
    int unsigned n;
    int unsigned total;
    n = 1 << sel;
    total = 0;
    for (int unsigned i = 0; i < n; i++) total += int'(rom_a[i]) * int'(rom_b[i]);
    e.n   = 4'(n);
    e.ovf = (total > 255);
    e.res = (total > 255) ? 8'hFF : 8'(total);
    return e;
  endfunction

  task automatic load_roms(input int mode);
    for (int unsigned i = 0; i < 16; i++) begin
      rom_a[i] = (mode == 0) ? 4'(i + 1) : 4'd15;
      rom_b[i] = (mode == 0) ? 4'd2 : 4'd15;
    end
  endtask

  // Returns at the negedge right after the accept edge.
  task automatic start_run(input logic [1:0] sel);
    @(negedge clk);
    sample_sel = sel;
    start = 1'b1;
    sb.push_back(model(sel));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int unsigned busy_cycles, output bit timed_out);
    busy_cycles = 0;
    timed_out = 1'b1;
    addr_trace.delete();
    for (int unsigned k = 0; k < 100; k++) begin
      if (busy) begin
        busy_cycles++;
        addr_trace.push_back(rom_addr);
      end else if (done) begin
        addr_trace.push_back(rom_addr);
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rom_addr, busy, done, overflow, result, n_active} !== '0) begin
      errors++;
      $display("FAIL reset_values: addr=%0d busy=%b done=%b ovf=%b result=%0d n=%0d expected all 0",
               rom_addr, busy, done, overflow, result, n_active);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    int unsigned bc;
    bit          to;
    exp_t        e;
    start_run(2'd0);
    wait_done(bc, to);
    e = sb.pop_front();
    checks++;
    if (to || bc != 2) begin
      errors++;
      $display("FAIL single_busy: busy_cycles=%0d timeout=%b expected 2", bc, to);
    end
    checks++;
    if ({result, overflow, n_active} !== {e.res, e.ovf, e.n}) begin
      errors++;
      $display("FAIL single_result: result=%0d ovf=%b n=%0d expected %0d %b %0d",
               result, overflow, n_active, e.res, e.ovf, e.n);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 8'd2) begin
      errors++;
      $display("FAIL single_sticky: done=%b result=%0d expected 1 2", done, result);
    end
  endtask

  task automatic test_lengths();
    int unsigned bc;
    bit          to;
    exp_t        e;
    int unsigned n;
    for (int unsigned s = 1; s < 4; s++) begin
      n = 1 << s;
      start_run(2'(s));
      wait_done(bc, to);
      e = sb.pop_front();
      checks++;
      if (to || bc != n + 1) begin
        errors++;
        $display("FAIL len_busy sel=%0d: busy_cycles=%0d timeout=%b expected %0d", s, bc, to, n + 1);
      end
      checks++;
      if ({result, overflow, n_active} !== {e.res, e.ovf, e.n}) begin
        errors++;
        $display("FAIL len_result sel=%0d: result=%0d ovf=%b n=%0d expected %0d %b %0d",
                 s, result, overflow, n_active, e.res, e.ovf, e.n);
      end
      checks++;
      if (addr_trace.size() != n + 2) begin
        errors++;
        $display("FAIL len_addr_count sel=%0d: got %0d addresses expected %0d", s, addr_trace.size(), n + 2);
      end else begin
        for (int unsigned k = 0; k < n + 2; k++) begin
          checks++;
          if (addr_trace[k] !== ((k <= n) ? 4'(k) : 4'd0)) begin
            errors++;
            $display("FAIL len_addr sel=%0d step=%0d: addr=%0d expected %0d",
                     s, k, addr_trace[k], (k <= n) ? k : 0);
          end
        end
      end
    end
  endtask

  task automatic test_saturate();
    int unsigned bc;
    bit          to;
    exp_t        e;
    load_roms(1);
    for (int unsigned r = 0; r < 2; r++) begin
      start_run((r == 0) ? 2'd3 : 2'd0);
      wait_done(bc, to);
      e = sb.pop_front();
      checks++;
      if (to || {result, overflow, n_active} !== {e.res, e.ovf, e.n}) begin
        errors++;
        $display("FAIL saturate run=%0d: result=%0d ovf=%b n=%0d timeout=%b expected %0d %b %0d",
                 r, result, overflow, n_active, to, e.res, e.ovf, e.n);
      end
    end
    load_roms(0);
  endtask

  task automatic test_hold_start();
    int unsigned runs;
    logic        prev;
    exp_t        e;
    @(negedge clk);
    sample_sel = 2'd0;
    start = 1'b1;
    sb.push_back(model(2'd0));
    runs = 0;
    prev = busy;
    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy && !prev) runs++;
      prev = busy;
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (runs != 1) begin
      errors++;
      $display("FAIL hold_runs: runs=%0d expected 1", runs);
    end
    checks++;
    if (done !== 1'b1 || {result, overflow, n_active} !== {e.res, e.ovf, e.n}) begin
      errors++;
      $display("FAIL hold_result: done=%b result=%0d ovf=%b n=%0d expected 1 %0d %b %0d",
               done, result, overflow, n_active, e.res, e.ovf, e.n);
    end
  endtask

  task automatic test_ignore_busy();
    int unsigned bc;
    bit          to;
    exp_t        e;
    start_run(2'd2);
    start = 1'b1;
    sample_sel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    sample_sel = 2'd0;
    wait_done(bc, to);
    e = sb.pop_front();
    checks++;
    if (to || {result, overflow, n_active} !== {e.res, e.ovf, e.n}) begin
      errors++;
      $display("FAIL ignore_result: result=%0d ovf=%b n=%0d timeout=%b expected %0d %b %0d",
               result, overflow, n_active, to, e.res, e.ovf, e.n);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_no_retrigger: busy=%b done=%b expected 0 1", busy, done);
    end
  endtask

  task automatic test_reset_midrun();
    int unsigned bc;
    bit          to;
    exp_t        e;
    start_run(2'd3);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    e = sb.pop_front();
    checks++;
    if ({rom_addr, busy, done, overflow, result, n_active} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: addr=%0d busy=%b done=%b ovf=%b result=%0d n=%0d expected all 0",
               rom_addr, busy, done, overflow, result, n_active);
    end
    @(negedge clk);
    reset = 1'b1;
    start_run(2'd2);
    wait_done(bc, to);
    e = sb.pop_front();
    checks++;
    if (to || bc != 5 || result !== 8'd20 || {result, overflow, n_active} !== {e.res, e.ovf, e.n}) begin
      errors++;
      $display("FAIL midrun_restart: result=%0d ovf=%b n=%0d busy_cycles=%0d expected %0d %b %0d 5",
               result, overflow, n_active, bc, e.res, e.ovf, e.n);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned bc;
    bit          to;
    exp_t        e;
    start_run(2'd1);
    wait_done(bc, to);
    e = sb.pop_front();
    checks++;
    if (to || {result, overflow, n_active} !== {e.res, e.ovf, e.n}) begin
      errors++;
      $display("FAIL b2b_first: result=%0d ovf=%b n=%0d expected %0d %b %0d",
               result, overflow, n_active, e.res, e.ovf, e.n);
    end
    sample_sel = 2'd2;
    start = 1'b1;
    sb.push_back(model(2'd2));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || result !== 8'd6) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b result=%0d expected 0 1 6", done, busy, result);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 8'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: result=%0d busy=%b expected 6 1", result, busy);
    end
    wait_done(bc, to);
    e = sb.pop_front();
    checks++;
    if (to || {result, overflow, n_active} !== {e.res, e.ovf, e.n}) begin
      errors++;
      $display("FAIL b2b_second: result=%0d ovf=%b n=%0d expected %0d %b %0d",
               result, overflow, n_active, e.res, e.ovf, e.n);
    end
  endtask

  initial begin
    load_roms(0);
    test_reset();
    test_single();
    test_lengths();
    test_saturate();
    test_hold_start();
    test_ignore_busy();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
